uart_tx_arbiter: RTL and testbench

Shares one 16x-oversampled UART transmitter among NUM_REQ byte sources. It picks requesters by round-robin, launches one frame per grant with a single-cycle `tx_en` pulse, and waits for the transmitter's completion. It also guards each frame with a watchdog timeout. It sits between the producer blocks (command responders, loggers, debug taps) and the transmitter instance.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter states, byte width, oversampling.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int SAMPLE_AMT     = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        DRAIN     = 2'd2
    } arb_state_t;

    // Index width for n requesters; a single requester still gets a 1-bit index.
    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req scanning from rr_ptr upward with wrap.
// Zero latency; no backpressure, any flags whether a winner exists.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    int idx;

    // Descending scan so the lowest rotated position overwrites last and wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                winner = IDW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; one tx_en per grant, waits for tx_done or watchdog.
// Grant one cycle after req_valid in IDLE; requesters hold valid until their req_ready pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [idw(NUM_REQ)-1:0]       owner,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int IDW = idw(NUM_REQ);
    localparam int TW  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] next_ptr;
    logic           any;
    logic [TW-1:0]  timer;
    logic           tx_done_q;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .winner  (win),
        .any     (any)
    );

    assign next_ptr = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            timer       <= '0;
            tx_done_q   <= 1'b0;
            req_ready   <= '0;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_done_q   <= tx_done;
            req_ready   <= '0;
            tx_en       <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A high tx_done here means the transmitter is still finishing a frame.
                    if (any && !tx_done) begin
                        req_ready <= NUM_REQ'(1) << win;
                        tx_en     <= 1'b1;
                        tx_data   <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
                        owner     <= win;
                        rr_ptr    <= next_ptr;
                        timer     <= '0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (timer != TW'(TIMEOUT_CYCLES)) timer <= timer + 1'b1;
                    if (tx_done && !tx_done_q) begin
                        frame_done <= 1'b1;
                        state      <= DRAIN;
                    end else if (TIMEOUT_CYCLES != 0 && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with NUM_REQ=4, TIMEOUT_CYCLES=100.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  owner;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    int n_chk  = 0;
    int n_pass = 0;
    int frame_cnt   = 0;
    int timeout_cnt = 0;
    int txen_cnt    = 0;
    int overlap_cnt = 0;

    uart_tx_arbiter #(
        .DATA_WIDTH     (8),
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .owner       (owner),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)      frame_cnt++;
        if (timeout_err)     timeout_cnt++;
        if (tx_en)           txen_cnt++;
        if (tx_en && tx_done) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_tx_en"},     32'(tx_en),     32'h0);
        check({tag, "_tx_data"},   32'(tx_data),   32'h0);
        check({tag, "_owner"},     32'(owner),     32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_flags"},     32'({frame_done, timeout_err}), 32'h0);
    endtask

    initial begin
        int steps;
        int f0;
        int t0;
        int e0;
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = 32'h0;
        tx_done   = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        resetn = 1'b1;

        // Single request from lane 2, then a 20-cycle tx_done level.
        req_data  = 32'h44_A5_22_11;
        req_valid = 4'b0100;
        step();
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_tx_en", 32'(tx_en), 32'h1);
        check("single_data",  32'(tx_data), 32'hA5);
        check("single_owner", 32'(owner), 32'h2);
        req_valid = '0;
        step();
        check("single_pulse", 32'({tx_en, req_ready}), 32'h0);
        check("single_busy",  32'(busy), 32'h1);
        tx_done = 1'b1;
        step();
        check("single_fdone", 32'(frame_done), 32'h1);
        for (int i = 1; i < 20; i++) step();
        check("drain_busy", 32'(busy), 32'h1);
        tx_done = 1'b0;
        step();
        check("drain_idle", 32'(busy), 32'h0);
        check("single_frames", 32'(frame_cnt), 32'd1);
        check("single_data_hold", 32'(tx_data), 32'hA5);

        // Watchdog: rr_ptr is 3, only lane 0 requests; tx_done never rises.
        set_lane(0, 8'h3C);
        req_valid = 4'b0001;
        step();
        check("wd_owner", 32'({tx_en, 2'b00, owner}), 32'h10);
        req_valid = '0;
        steps = 0;
        while (!timeout_err && steps < 200) begin
            step();
            steps++;
        end
        check("wd_latency", 32'(steps), 32'd100);
        check("wd_no_fdone", 32'(frame_cnt), 32'd1);
        step();
        check("wd_idle", 32'(busy), 32'h0);

        // Next grant proceeds; completion coincides with expiry cycle.
        set_lane(1, 8'h77);
        req_valid = 4'b0010;
        step();
        check("tie_grant", 32'({tx_en, 2'b00, owner}), 32'h11);
        req_valid = '0;
        for (int i = 0; i < 99; i++) step();
        tx_done = 1'b1;
        step();
        check("tie_flags", 32'({frame_done, timeout_err}), 32'h2);
        step();
        check("tie_timeouts", 32'(timeout_cnt), 32'd1);
        tx_done = 1'b0;
        step();
        check("tie_idle", 32'(busy), 32'h0);

        // Reset during WAIT_DONE, then tx_done stuck high after reset.
        set_lane(2, 8'h5A);
        req_valid = 4'b0100;
        step();
        check("mid_grant", 32'({tx_data, 6'b0, owner}), 32'h5A02);
        req_valid = '0;
        step();
        resetn = 1'b0;
        step();
        check_reset_outputs("mid_rst");
        resetn    = 1'b1;
        tx_done   = 1'b1;
        req_valid = 4'b1010;
        e0 = txen_cnt;
        for (int i = 0; i < 5; i++) step();
        check("stuck_no_grant", 32'(txen_cnt - e0), 32'd0);
        check("stuck_idle", 32'(busy), 32'h0);
        tx_done = 1'b0;
        step();
        check("stuck_release", 32'({tx_en, req_ready}), 32'h12);
        check("stuck_owner", 32'(owner), 32'h1);
        req_valid = '0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();

        resetn = 1'b0;
        step();
        resetn = 1'b1;

        // Round-robin with all four lanes continuously valid.
        req_data  = 32'h13_12_11_10;
        req_valid = 4'hF;
        f0 = frame_cnt;
        for (int k = 0; k < 5; k++) begin
            steps = 0;
            while (!tx_en && steps < 10) begin
                step();
                steps++;
            end
            check($sformatf("rr%0d_gap", k), 32'(steps), (k == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_owner", k), 32'({tx_data, 2'b0, req_ready, 2'b0, owner}),
                  32'({8'h10 + 8'(k % 4), 2'b0, 4'(1 << (k % 4)), 2'b0, 2'(k % 4)}));
            step();
            tx_done = 1'b1;
            step();
            step();
            tx_done = 1'b0;
        end
        req_valid = '0;
        step();
        step();
        check("rr_frames", 32'(frame_cnt - f0), 32'd5);
        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
